// File: rtl/si5338_cfg_sequencer.sv
// Si5338 power-up programming sequencer: walks a register-map ROM and drives an
// external single-byte I2C master through a req/done handshake, with read-modify-write.
module si5338_cfg_sequencer #(
  parameter int CLK_FREQ    = 50_000_000,
  parameter int TABLE_LEN   = 350,
  parameter int SETTLE_US   = 25_000,
  parameter int POLL_MAX    = 1000,
  parameter int POLL_GAP_US = 100
) (
  input  logic        CLK,
  input  logic        RSTn,
  input  logic        start,
  output logic [8:0]  rom_addr,
  input  logic [23:0] rom_data,
  output logic        i2c_req,
  output logic        i2c_rnw,
  output logic [7:0]  i2c_reg,
  output logic [7:0]  i2c_wdata,
  input  logic        i2c_done,
  input  logic        i2c_nack,
  input  logic [7:0]  i2c_rdata,
  output logic        osc_done,
  output logic        busy,
  output logic        err,
  output logic [2:0]  err_code
);

  // 64-bit math so 25 ms at high clock rates cannot overflow.
  localparam longint SETTLE_CYC = (longint'(SETTLE_US) * longint'(CLK_FREQ)) / longint'(1_000_000);
  localparam longint GAP_CYC    = (longint'(POLL_GAP_US) * longint'(CLK_FREQ)) / longint'(1_000_000);
  localparam longint TMR_MAX    = (SETTLE_CYC > GAP_CYC) ? SETTLE_CYC : GAP_CYC;
  localparam int     TMR_W      = (TMR_MAX < 2) ? 1 : $clog2(TMR_MAX + 1);
  localparam int     POLL_W     = (POLL_MAX < 2) ? 1 : $clog2(POLL_MAX + 1);

  localparam logic [TMR_W-1:0]  SETTLE_LD = TMR_W'(SETTLE_CYC);
  localparam logic [TMR_W-1:0]  GAP_LD    = TMR_W'(GAP_CYC);
  localparam logic [POLL_W-1:0] POLL_LAST = POLL_W'(POLL_MAX);
  localparam logic [8:0]        LAST_ADDR = 9'(TABLE_LEN - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_OEB, S_DISLOL, S_TABLE, S_POLL_LOS, S_FCAL_OFF, S_SRST, S_SETTLE,
    S_ENLOL, S_POLL_LOCK, S_FCAL_CPY, S_FCAL_ON, S_OEN, S_DONE, S_ERR
  } state_t;

  function automatic logic [7:0] merge_byte(input logic [7:0] value,
                                            input logic [7:0] mask,
                                            input logic [7:0] rd);
    return (value & mask) | (rd & ~mask);
  endfunction

  state_t             state_q, state_d;
  logic [2:0]         step_q, step_d;
  logic               req_q, req_d;
  logic               rnw_q, rnw_d;
  logic [7:0]         reg_q, reg_d;
  logic [7:0]         wdata_q, wdata_d;
  logic [7:0]         rdata_q, rdata_d;
  logic [23:0]        ent_q, ent_d;
  logic [8:0]         addr_q, addr_d;
  logic [POLL_W-1:0]  poll_q, poll_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic               osc_done_q, osc_done_d;
  logic               err_q, err_d;
  logic [2:0]         err_code_q, err_code_d;

  logic               op_go, op_rnw;
  logic [7:0]         op_reg, op_wdata;
  logic               xfer_ok, tbl_adv;
  logic [7:0]         rmw_reg, rmw_val, rmw_mask;
  state_t             rmw_next;
  logic [7:0]         wr_reg, wr_val;
  state_t             wr_next;
  logic [7:0]         poll_mask;
  state_t             poll_next;
  logic [2:0]         poll_code;

  // Fixed register operations of the bring-up procedure, selected by phase.
  always_comb begin
    rmw_reg  = 8'd230;
    rmw_val  = 8'h10;
    rmw_mask = 8'h10;
    rmw_next = S_DISLOL;
    wr_reg   = 8'd241;
    wr_val   = 8'hE5;
    wr_next  = S_TABLE;
    poll_mask = 8'h04;
    poll_next = S_FCAL_OFF;
    poll_code = 3'd2;
    case (state_q)
      S_FCAL_OFF: begin rmw_reg = 8'd49;  rmw_val = 8'h00; rmw_mask = 8'h80; rmw_next = S_SRST; end
      S_FCAL_ON:  begin rmw_reg = 8'd49;  rmw_val = 8'h80; rmw_mask = 8'h80; rmw_next = S_OEN;  end
      S_OEN:      begin rmw_reg = 8'd230; rmw_val = 8'h00; rmw_mask = 8'h10; rmw_next = S_DONE; end
      S_SRST:     begin wr_reg = 8'd246; wr_val = 8'h02; wr_next = S_SETTLE;    end
      S_ENLOL:    begin wr_reg = 8'd241; wr_val = 8'h65; wr_next = S_POLL_LOCK; end
      S_POLL_LOCK: begin poll_mask = 8'h15; poll_next = S_FCAL_CPY; poll_code = 3'd3; end
      default: ;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    step_d     = step_q;
    req_d      = req_q;
    rnw_d      = rnw_q;
    reg_d      = reg_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    ent_d      = ent_q;
    addr_d     = addr_q;
    poll_d     = poll_q;
    tmr_d      = tmr_q;
    osc_done_d = osc_done_q;
    err_d      = err_q;
    err_code_d = err_code_q;
    op_go      = 1'b0;
    op_rnw     = 1'b0;
    op_reg     = 8'h00;
    op_wdata   = 8'h00;
    tbl_adv    = 1'b0;
    xfer_ok    = req_q & i2c_done & ~i2c_nack;

    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d    = S_OEB;
          step_d     = 3'd0;
          osc_done_d = 1'b0;
          err_d      = 1'b0;
          err_code_d = 3'd0;
        end
      end

      S_OEB, S_FCAL_OFF, S_FCAL_ON, S_OEN: begin
        op_go    = 1'b1;
        op_rnw   = (step_q == 3'd0);
        op_reg   = rmw_reg;
        op_wdata = merge_byte(rmw_val, rmw_mask, rdata_q);
        if (xfer_ok) begin
          if (step_q == 3'd0) begin
            step_d = 3'd1;
          end else begin
            state_d = rmw_next;
            step_d  = 3'd0;
            if (rmw_next == S_DONE) osc_done_d = 1'b1;
          end
        end
      end

      S_DISLOL, S_SRST, S_ENLOL: begin
        op_go    = 1'b1;
        op_reg   = wr_reg;
        op_wdata = wr_val;
        if (xfer_ok) begin
          state_d = wr_next;
          step_d  = 3'd0;
          addr_d  = 9'd0;
          poll_d  = '0;
          tmr_d   = (state_q == S_SRST) ? SETTLE_LD : '0;
        end
      end

      // Step 0 absorbs the ROM latency; step 1 classifies the entry by its mask.
      S_TABLE: begin
        case (step_q)
          3'd0: step_d = 3'd1;
          3'd1: begin
            ent_d = rom_data;
            if (rom_data[7:0] == 8'h00)      tbl_adv = 1'b1;
            else if (rom_data[7:0] == 8'hFF) step_d  = 3'd3;
            else                             step_d  = 3'd2;
          end
          3'd2: begin
            op_go  = 1'b1;
            op_rnw = 1'b1;
            op_reg = ent_q[23:16];
            if (xfer_ok) step_d = 3'd3;
          end
          3'd3: begin
            op_go    = 1'b1;
            op_reg   = ent_q[23:16];
            op_wdata = merge_byte(ent_q[15:8], ent_q[7:0], rdata_q);
            if (xfer_ok) tbl_adv = 1'b1;
          end
          default: step_d = 3'd0;
        endcase
        if (tbl_adv) begin
          step_d = 3'd0;
          if (addr_q == LAST_ADDR) begin
            state_d = S_POLL_LOS;
            poll_d  = '0;
            tmr_d   = '0;
          end else begin
            addr_d = addr_q + 9'd1;
          end
        end
      end

      S_POLL_LOS, S_POLL_LOCK: begin
        op_go  = (tmr_q == '0);
        op_rnw = 1'b1;
        op_reg = 8'd218;
        if (!req_q && tmr_q != '0) tmr_d = tmr_q - TMR_W'(1);
        if (xfer_ok) begin
          poll_d = poll_q + POLL_W'(1);
          if ((i2c_rdata & poll_mask) == 8'h00) begin
            state_d = poll_next;
            step_d  = 3'd0;
          end else if ((poll_q + POLL_W'(1)) == POLL_LAST) begin
            state_d    = S_ERR;
            err_d      = 1'b1;
            err_code_d = poll_code;
          end else begin
            tmr_d = GAP_LD;
          end
        end
      end

      S_SETTLE: begin
        if (tmr_q <= TMR_W'(1)) begin
          state_d = S_ENLOL;
          step_d  = 3'd0;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end

      // Even steps read 235/236/237, odd steps write 45/46/47.
      S_FCAL_CPY: begin
        op_go  = 1'b1;
        op_rnw = ~step_q[0];
        case (step_q[2:1])
          2'd0:    op_reg = step_q[0] ? 8'd45 : 8'd235;
          2'd1:    op_reg = step_q[0] ? 8'd46 : 8'd236;
          default: op_reg = step_q[0] ? 8'd47 : 8'd237;
        endcase
        op_wdata = (step_q == 3'd5) ? (8'h14 | (rdata_q & 8'h03)) : rdata_q;
        if (xfer_ok) begin
          if (step_q == 3'd5) begin
            state_d = S_FCAL_ON;
            step_d  = 3'd0;
          end else begin
            step_d = step_q + 3'd1;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Shared bus handshake; the cycle after done is always idle on req.
    if (!req_q) begin
      if (op_go) begin
        req_d   = 1'b1;
        rnw_d   = op_rnw;
        reg_d   = op_reg;
        wdata_d = op_rnw ? 8'h00 : op_wdata;
      end
    end else if (i2c_done) begin
      req_d = 1'b0;
      if (rnw_q) rdata_d = i2c_rdata;
      if (i2c_nack) begin
        state_d    = S_ERR;
        step_d     = 3'd0;
        err_d      = 1'b1;
        err_code_d = 3'd1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      state_q    <= S_IDLE;
      step_q     <= 3'd0;
      req_q      <= 1'b0;
      rnw_q      <= 1'b0;
      reg_q      <= 8'h00;
      wdata_q    <= 8'h00;
      rdata_q    <= 8'h00;
      ent_q      <= 24'h0;
      addr_q     <= 9'd0;
      poll_q     <= '0;
      tmr_q      <= '0;
      osc_done_q <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= 3'd0;
    end else begin
      state_q    <= state_d;
      step_q     <= step_d;
      req_q      <= req_d;
      rnw_q      <= rnw_d;
      reg_q      <= reg_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      ent_q      <= ent_d;
      addr_q     <= addr_d;
      poll_q     <= poll_d;
      tmr_q      <= tmr_d;
      osc_done_q <= osc_done_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
    end
  end

  assign rom_addr  = addr_q;
  assign i2c_req   = req_q;
  assign i2c_rnw   = rnw_q;
  assign i2c_reg   = reg_q;
  assign i2c_wdata = wdata_q;
  assign osc_done  = osc_done_q;
  assign err       = err_q;
  assign err_code  = err_code_q;
  assign busy      = !(state_q inside {S_IDLE, S_DONE, S_ERR});

endmodule

// File: tb/tb_si5338_cfg_sequencer.sv
// Bench for si5338_cfg_sequencer: behavioural I2C slave with register memory and a
// scoreboard of expected bus transactions; small timing parameters keep runs short.
module tb_si5338_cfg_sequencer;

  localparam int CLK_FREQ    = 1_000_000;
  localparam int TABLE_LEN   = 4;
  localparam int SETTLE_US   = 300;
  localparam int POLL_MAX    = 6;
  localparam int POLL_GAP_US = 5;
  localparam int SETTLE_CYC  = SETTLE_US * CLK_FREQ / 1_000_000;
  localparam int GAP_CYC     = POLL_GAP_US * CLK_FREQ / 1_000_000;
  localparam int LAT         = 3;
  localparam int BUDGET      = 5000;

  logic        CLK = 1'b0;
  logic        RSTn = 1'b0;
  logic        start = 1'b0;
  logic [8:0]  rom_addr;
  logic [23:0] rom_data;
  logic        i2c_req, i2c_rnw;
  logic [7:0]  i2c_reg, i2c_wdata;
  logic        i2c_done, i2c_nack;
  logic [7:0]  i2c_rdata;
  logic        osc_done, busy, err;
  logic [2:0]  err_code;

  si5338_cfg_sequencer #(
    .CLK_FREQ(CLK_FREQ), .TABLE_LEN(TABLE_LEN), .SETTLE_US(SETTLE_US),
    .POLL_MAX(POLL_MAX), .POLL_GAP_US(POLL_GAP_US)
  ) dut (
    .CLK(CLK), .RSTn(RSTn), .start(start), .rom_addr(rom_addr), .rom_data(rom_data),
    .i2c_req(i2c_req), .i2c_rnw(i2c_rnw), .i2c_reg(i2c_reg), .i2c_wdata(i2c_wdata),
    .i2c_done(i2c_done), .i2c_nack(i2c_nack), .i2c_rdata(i2c_rdata),
    .osc_done(osc_done), .busy(busy), .err(err), .err_code(err_code)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  logic [23:0] rom [4];
  initial begin
    rom[0] = {8'd6,  8'h1D, 8'hFF};
    rom[1] = {8'd28, 8'h0B, 8'h00};
    rom[2] = {8'd31, 8'hC0, 8'hE0};
    rom[3] = {8'd40, 8'h84, 8'hFF};
  end
  always @(posedge CLK) rom_data <= rom[rom_addr[1:0]];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Scoreboard entry: {rnw, reg, write byte (0 for reads)}.
  logic [16:0] expq[$];
  function automatic logic [16:0] rd_t(input logic [7:0] r);
    return {1'b1, r, 8'h00};
  endfunction
  function automatic logic [16:0] wr_t(input logic [7:0] r, input logic [7:0] v);
    return {1'b0, r, v};
  endfunction

  logic [7:0] mem [256];
  int los_left, los_reads, last218, srst_cyc;
  bit lock_stuck, nack_arm, after_srst;

  task automatic prep(input int los, input bit stuck, input bit nk);
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[230] = 8'h2C; mem[49] = 8'h9A; mem[31] = 8'h1F;
    mem[235] = 8'hAA; mem[236] = 8'hBB; mem[237] = 8'h02;
    los_left = los; lock_stuck = stuck; nack_arm = nk;
    after_srst = 1'b0; los_reads = 0; last218 = -1; srst_cyc = 0;
    expq.delete();
  endtask

  task automatic push_prefix();
    expq.push_back(rd_t(8'd230));
    expq.push_back(wr_t(8'd230, 8'h3C));
    expq.push_back(wr_t(8'd241, 8'hE5));
  endtask
  task automatic push_table();
    expq.push_back(wr_t(8'd6, 8'h1D));
    expq.push_back(rd_t(8'd31));
    expq.push_back(wr_t(8'd31, 8'hDF));
    expq.push_back(wr_t(8'd40, 8'h84));
  endtask
  task automatic push_tail(input int los);
    for (int i = 0; i <= los; i++) expq.push_back(rd_t(8'd218));
    expq.push_back(rd_t(8'd49));
    expq.push_back(wr_t(8'd49, 8'h1A));
    expq.push_back(wr_t(8'd246, 8'h02));
    expq.push_back(wr_t(8'd241, 8'h65));
  endtask
  task automatic push_finish();
    expq.push_back(rd_t(8'd218));
    expq.push_back(rd_t(8'd235));
    expq.push_back(wr_t(8'd45, 8'hAA));
    expq.push_back(rd_t(8'd236));
    expq.push_back(wr_t(8'd46, 8'hBB));
    expq.push_back(rd_t(8'd237));
    expq.push_back(wr_t(8'd47, 8'h16));
    expq.push_back(rd_t(8'd49));
    expq.push_back(wr_t(8'd49, 8'h9A));
    expq.push_back(rd_t(8'd230));
    expq.push_back(wr_t(8'd230, 8'h2C));
  endtask
  task automatic push_full(input int los);
    push_prefix(); push_table(); push_tail(los); push_finish();
  endtask

  // I2C slave model: accepts a request, answers after LAT cycles.
  bit          pend = 1'b0;
  int          wait_n = 0;
  logic [16:0] cur, key;
  logic [7:0]  rdv;
  bit          nkv;
  initial begin : i2c_model
    i2c_done = 1'b0; i2c_nack = 1'b0; i2c_rdata = 8'h00;
    forever begin
      @(posedge CLK); #1;
      if (!RSTn) begin
        pend = 1'b0; i2c_done = 1'b0; i2c_nack = 1'b0;
      end else if (i2c_done) begin
        i2c_done = 1'b0; i2c_nack = 1'b0;
        chk("req_drop_after_done", i2c_req, 1'b0);
      end else if (pend) begin
        chk("fields_stable", {i2c_req, i2c_rnw, i2c_reg, i2c_wdata}, {1'b1, cur});
        wait_n--;
        if (wait_n == 0) begin
          rdv = mem[cur[15:8]]; nkv = 1'b0;
          if (cur[16]) begin
            if (cur[15:8] == 8'd218) begin
              if (!after_srst) begin
                los_reads++;
                rdv = (los_left > 0) ? 8'h04 : 8'h00;
                if (los_left > 0) los_left--;
              end else begin
                rdv = lock_stuck ? 8'h10 : 8'h00;
              end
            end
          end else if (nack_arm && cur[15:8] == 8'd241 && cur[7:0] == 8'hE5) begin
            nkv = 1'b1;
          end else begin
            mem[cur[15:8]] = cur[7:0];
            if (cur[15:8] == 8'd246) begin after_srst = 1'b1; srst_cyc = cyc; end
          end
          i2c_rdata = rdv; i2c_nack = nkv; i2c_done = 1'b1; pend = 1'b0;
        end
      end else if (i2c_req) begin
        cur = {i2c_rnw, i2c_reg, i2c_wdata};
        key = {i2c_rnw, i2c_reg, i2c_rnw ? 8'h00 : i2c_wdata};
        pend = 1'b1; wait_n = LAT;
        if (expq.size() == 0) chk("unexpected_txn", key, 17'h1FFFF);
        else chk("txn_order", key, expq.pop_front());
        if (key == rd_t(8'd218) && !after_srst) begin
          if (last218 >= 0) chk("los_poll_gap_ok", (cyc - last218) >= GAP_CYC, 1'b1);
          last218 = cyc;
        end
        // Settle span plus one cycle into SETTLE and one to raise req.
        if (key == wr_t(8'd241, 8'h65)) begin
          chk("settle_cycles_ok", ((cyc - srst_cyc) >= SETTLE_CYC + 1) &&
                                  ((cyc - srst_cyc) <= SETTLE_CYC + 3), 1'b1);
        end
      end
    end
  end

  task automatic pulse_start();
    @(negedge CLK) start = 1'b1;
    @(negedge CLK) start = 1'b0;
  endtask

  task automatic run_until_end(input string tag);
    int n;
    n = 0;
    while (!(osc_done || err) && n < BUDGET) begin
      @(posedge CLK); #1;
      n++;
    end
    chk({tag, "_finished_in_budget"}, n < BUDGET, 1'b1);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_req"}, i2c_req, 1'b0);
    chk({tag, "_rom_addr"}, rom_addr, 9'd0);
    chk({tag, "_osc_done"}, osc_done, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_err"}, err, 1'b0);
    chk({tag, "_err_code"}, err_code, 3'd0);
    chk({tag, "_bus_fields"}, {i2c_rnw, i2c_reg, i2c_wdata}, 17'h0);
  endtask

  initial begin : main
    int n;
    prep(0, 1'b0, 1'b0);
    repeat (3) @(negedge CLK);
    chk_idle_outputs("reset");
    RSTn = 1'b1;
    repeat (2) @(negedge CLK);

    // Full bring-up: three LOS-busy polls, ROM walk with skip and RMW.
    prep(3, 1'b0, 1'b0);
    push_full(3);
    pulse_start();
    chk("busy_after_start", busy, 1'b1);
    repeat (20) @(negedge CLK);
    pulse_start();
    run_until_end("full");
    chk("full_osc_done", osc_done, 1'b1);
    chk("full_err", err, 1'b0);
    chk("full_busy", busy, 1'b0);
    chk("full_queue_drained", expq.size(), 0);
    chk("full_los_reads", los_reads, 4);
    chk("full_reg47", mem[47], 8'h16);
    repeat (10) @(negedge CLK);
    chk("osc_done_held", osc_done, 1'b1);

    // NACK on the DISLOL write, then restart from ERR.
    prep(0, 1'b0, 1'b1);
    push_prefix();
    pulse_start();
    chk("done_cleared_by_start", osc_done, 1'b0);
    run_until_end("nack");
    chk("nack_err", err, 1'b1);
    chk("nack_err_code", err_code, 3'd1);
    chk("nack_osc_done", osc_done, 1'b0);
    chk("nack_busy", busy, 1'b0);
    chk("nack_queue_drained", expq.size(), 0);
    prep(0, 1'b0, 1'b0);
    push_full(0);
    pulse_start();
    chk("restart_err_cleared", err, 1'b0);
    chk("restart_code_cleared", err_code, 3'd0);
    run_until_end("restart");
    chk("restart_osc_done", osc_done, 1'b1);
    chk("restart_queue_drained", expq.size(), 0);

    // Lock never asserts: POLL_MAX reads then err_code 3, no further writes.
    prep(0, 1'b1, 1'b0);
    push_prefix(); push_table(); push_tail(0);
    for (int i = 0; i < POLL_MAX; i++) expq.push_back(rd_t(8'd218));
    pulse_start();
    run_until_end("lock_to");
    chk("lock_to_err", err, 1'b1);
    chk("lock_to_err_code", err_code, 3'd3);
    chk("lock_to_osc_done", osc_done, 1'b0);
    repeat (20) @(negedge CLK);
    chk("lock_to_no_more_req", i2c_req, 1'b0);
    chk("lock_to_queue_drained", expq.size(), 0);

    // Reset while the table write of reg 40 is pending.
    prep(0, 1'b0, 1'b0);
    push_prefix(); push_table();
    pulse_start();
    chk("err_cleared_by_start", err, 1'b0);
    n = 0;
    while (!(i2c_req && !i2c_rnw && i2c_reg == 8'd40) && n < BUDGET) begin
      @(posedge CLK); #1;
      n++;
    end
    chk("reg40_write_seen", n < BUDGET, 1'b1);
    @(negedge CLK) RSTn = 1'b0;
    @(posedge CLK); #1;
    chk_idle_outputs("midreset");
    chk("midreset_queue_drained", expq.size(), 0);
    repeat (2) @(negedge CLK);
    RSTn = 1'b1;
    prep(0, 1'b0, 1'b0);
    push_full(0);
    repeat (2) @(negedge CLK);
    pulse_start();
    run_until_end("replay");
    chk("replay_osc_done", osc_done, 1'b1);
    chk("replay_err", err, 1'b0);
    chk("replay_queue_drained", expq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin : watchdog
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
